hw_scan_ctrl: RTL and testbench
===============================

# hw_scan_ctrl

Sequencing controller for the Hamming-weight / set-bit-index datapath. It accepts one 1024-bit vector per transaction and walks it one 32-bit word per cycle. It streams the bit index of each set bit, up to a cap of 32, over a valid/ready port, and then presents the total set-bit count on a result handshake. It sits between the test-vector source and the result checker/writer, and replaces the unbounded single-pass loop with a bounded, backpressurable scan.

## Interface
- VEC_W, 1024: input vector width; power of two, multiple of WORD_W.
- WORD_W, 32: bits examined per scan step; power of two.
- MAX_LOC, 32: maximum number of locations emitted per vector.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  vector offered.
- in_ready  out  1  high only in IDLE.
- in_data  in  VEC_W  vector; bit i has index i.
- loc_valid  out  1  location beat valid.
- loc_ready  in  1  consumer accepts location.
- loc_data  out  log2(VEC_W) (10)  index of a set bit.
- loc_ord  out  log2(MAX_LOC) (5)  ordinal of this beat within the vector, 0-based.
- done_valid  out  1  result valid.
- done_ready  in  1  result accepted.
- done_count  out  log2(VEC_W)+1 (11)  total set bits, 0..1024; no wrap.
- done_trunc  out  1  done_count > MAX_LOC.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: in_ready=1. On in_valid:
  - capture the vector; load word 0 into cur_word;
  - set word_idx=0 and loc_num=0;
  - set count = popcount(word 0);
  - go to SCAN.
- SCAN: exactly one of the following per cycle.
  - Emit: when cur_word!=0 and loc_num<MAX_LOC.
    - loc_valid=1; loc_data={word_idx, index of lowest set bit of cur_word}; loc_ord=loc_num.
    - On loc_ready: clear that bit in cur_word and increment loc_num.
    - Without loc_ready: state and outputs hold.
  - Advance: when cur_word==0 or loc_num==MAX_LOC.
    - If word_idx is the last word: go to DONE.
    - Otherwise: increment word_idx, load the next word, and add its popcount to count.
  - Once the cap is reached, the remaining words are still popcounted but emit no locations.
- DONE: done_valid=1; done_count=count; done_trunc=(count>MAX_LOC). On done_ready, go to IDLE.
- Accumulate count at 11 bits; the all-ones vector yields 1024 exactly.
- in_valid is ignored outside IDLE. No new vector is accepted in the same cycle as done_ready.

## Timing
- Reset values:
  - state=IDLE, so in_ready=1;
  - loc_valid=0, loc_data=0, loc_ord=0;
  - done_valid=0, done_count=0, done_trunc=0.
- Reset mid-operation abandons the vector. No further loc beats or done are produced for it.
- Accept edge = cycle 0. With loc_ready held high, done_valid rises at cycle (VEC_W/WORD_W) + min(N, MAX_LOC), where N is the vector's set-bit count. That is 32 cycles for all-zero and 64 for all-ones.
- Each cycle of loc_ready=0 during a pending beat adds one cycle of latency.
- loc_data and loc_ord are stable while loc_valid=1 and loc_ready=0.
- done_count and done_trunc are stable while done_valid=1 and done_ready=0.
- Earliest next accept is the cycle after the done_ready handshake.
- Locations are registered outputs. Popcount and lowest-set-bit logic are combinational on cur_word.

## Configuration
- HWSCAN_MSB_FIRST_EN defined:
  - scan starts at the highest word and decrements;
  - each beat emits the highest set bit of cur_word;
  - locations come out in descending order and the cap keeps the MAX_LOC highest indices.
- Not defined: ascending order, word 0 first, lowest bit first.
- Count, latency and handshakes are identical in both builds.

## Test plan
- All-zero vector, loc_ready=1 -> no loc beats; done_valid at cycle 32; done_count=0; done_trunc=0.
- Bits {0,31,32,1023} set -> beats (loc_data,loc_ord)=(0,0),(31,1),(32,2),(1023,3); done_count=4 at cycle 36; done_trunc=0.
- All-ones -> 32 beats with loc_data 0..31 and loc_ord 0..31; done_count=1024; done_trunc=1; done_valid at cycle 64.
- Bits {5,700} set, loc_ready low for 5 cycles on the first beat -> loc_data=5 held stable; done_count=2; done_valid at cycle 39. Then done_ready low for 3 cycles -> done holds and in_ready stays 0.
- rst pulsed after 3 of 10 beats -> all outputs at reset values, in_ready=1. The next vector {2} yields a single beat (2,0) and done_count=1.
- With HWSCAN_MSB_FIRST_EN, bits {3,1000} -> beats (1000,0),(3,1); done_count=2.

Source files
------------

// File: rtl/hw_scan_ctrl.sv
// Bounded set-bit scanner: walks a wide vector one word per cycle, streams set-bit indices (capped) and the total count.
// Define HWSCAN_MSB_FIRST_EN to scan from the highest word and highest bit downward.
module hw_scan_ctrl #(
  parameter int VEC_W   = 1024,
  parameter int WORD_W  = 32,
  parameter int MAX_LOC = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [VEC_W-1:0]           i_in_data,
  output logic                       o_loc_valid,
  input  logic                       i_loc_ready,
  output logic [$clog2(VEC_W)-1:0]   o_loc_data,
  output logic [$clog2(MAX_LOC)-1:0] o_loc_ord,
  output logic                       o_done_valid,
  input  logic                       i_done_ready,
  output logic [$clog2(VEC_W):0]     o_done_count,
  output logic                       o_done_trunc
);

  localparam int NWORDS = VEC_W / WORD_W;
  localparam int IDX_W  = $clog2(NWORDS);
  localparam int BIT_W  = $clog2(WORD_W);
  localparam int LOC_W  = $clog2(VEC_W);
  localparam int ORD_W  = $clog2(MAX_LOC);
  localparam int NUM_W  = ORD_W + 1;
  localparam int CNT_W  = LOC_W + 1;
  localparam logic [NUM_W-1:0] CAP = NUM_W'(MAX_LOC);

`ifdef HWSCAN_MSB_FIRST_EN
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(NWORDS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = '0;
`else
  localparam logic [IDX_W-1:0] FIRST_IDX = '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NWORDS - 1);
`endif

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             r_state, w_nextState;
  logic [VEC_W-1:0]   r_vec;
  logic [WORD_W-1:0]  r_curWord, w_nxtWord;
  logic [IDX_W-1:0]   r_wordIdx, w_nxtIdx;
  logic [NUM_W-1:0]   r_locNum, w_nxtLocNum;
  logic [CNT_W-1:0]   r_count, w_nxtCount;
  logic               r_locValid;
  logic [LOC_W-1:0]   r_locData;
  logic [ORD_W-1:0]   r_locOrd;
  logic [BIT_W-1:0]   w_nxtBit;
  logic               w_emit;

  function automatic logic [CNT_W-1:0] popcnt(input logic [WORD_W-1:0] w);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int b = 0; b < WORD_W; b++) s = s + {{(CNT_W-1){1'b0}}, w[b]};
    return s;
  endfunction

  always_comb begin
    w_nextState = r_state;
    w_nxtWord   = r_curWord;
    w_nxtIdx    = r_wordIdx;
    w_nxtLocNum = r_locNum;
    w_nxtCount  = r_count;
    w_emit      = (r_curWord != '0) && (r_locNum < CAP);
    case (r_state)
      IDLE: begin
        if (i_in_valid) begin
          w_nextState = SCAN;
          w_nxtIdx    = FIRST_IDX;
          w_nxtWord   = i_in_data[int'(FIRST_IDX)*WORD_W +: WORD_W];
          w_nxtLocNum = '0;
          w_nxtCount  = popcnt(w_nxtWord);
        end
      end
      SCAN: begin
        // r_locData's low bits always name the bit currently on offer, so clear exactly that one
        if (w_emit) begin
          if (i_loc_ready) begin
            w_nxtWord   = r_curWord & ~(WORD_W'(1) << r_locData[BIT_W-1:0]);
            w_nxtLocNum = r_locNum + 1'b1;
          end
        end else if (r_wordIdx == LAST_IDX) begin
          w_nextState = DONE;
        end else begin
`ifdef HWSCAN_MSB_FIRST_EN
          w_nxtIdx = r_wordIdx - 1'b1;
`else
          w_nxtIdx = r_wordIdx + 1'b1;
`endif
          w_nxtWord  = r_vec[int'(w_nxtIdx)*WORD_W +: WORD_W];
          w_nxtCount = r_count + popcnt(w_nxtWord);
        end
      end
      DONE: begin
        if (i_done_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Bit selector runs on the next word so the location outputs can be registered
  always_comb begin
    w_nxtBit = '0;
`ifdef HWSCAN_MSB_FIRST_EN
    for (int b = 0; b < WORD_W; b++) if (w_nxtWord[b]) w_nxtBit = BIT_W'(b);
`else
    for (int b = WORD_W - 1; b >= 0; b--) if (w_nxtWord[b]) w_nxtBit = BIT_W'(b);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_vec      <= '0;
      r_curWord  <= '0;
      r_wordIdx  <= '0;
      r_locNum   <= '0;
      r_count    <= '0;
      r_locValid <= 1'b0;
      r_locData  <= '0;
      r_locOrd   <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE && i_in_valid) r_vec <= i_in_data;
      r_curWord  <= w_nxtWord;
      r_wordIdx  <= w_nxtIdx;
      r_locNum   <= w_nxtLocNum;
      r_count    <= w_nxtCount;
      r_locValid <= (w_nextState == SCAN) && (w_nxtWord != '0) && (w_nxtLocNum < CAP);
      r_locData  <= {w_nxtIdx, w_nxtBit};
      r_locOrd   <= w_nxtLocNum[ORD_W-1:0];
    end
  end

  assign o_in_ready   = (r_state == IDLE);
  assign o_loc_valid  = r_locValid;
  assign o_loc_data   = r_locData;
  assign o_loc_ord    = r_locOrd;
  assign o_done_valid = (r_state == DONE);
  assign o_done_count = (r_state == DONE) ? r_count : '0;
  assign o_done_trunc = (r_state == DONE) && (r_count > CNT_W'(MAX_LOC));

endmodule

// File: tb/tb_hw_scan_ctrl.sv
// Bench for hw_scan_ctrl: set-bit list model plus per-cycle compare, and directed literal checks.
// Compile with HWSCAN_MSB_FIRST_EN to match the descending-order build.
module tb_hw_scan_ctrl;

  localparam int VEC_W   = 1024;
  localparam int WORD_W  = 32;
  localparam int MAX_LOC = 32;
  localparam int NWORDS  = VEC_W / WORD_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_in_valid = 1'b0;
  logic             o_in_ready;
  logic [VEC_W-1:0] i_in_data = '0;
  logic             o_loc_valid;
  logic             i_loc_ready = 1'b1;
  logic [9:0]       o_loc_data;
  logic [4:0]       o_loc_ord;
  logic             o_done_valid;
  logic             i_done_ready = 1'b0;
  logic [10:0]      o_done_count;
  logic             o_done_trunc;

  int checks = 0;
  int errors = 0;

  hw_scan_ctrl #(.VEC_W(VEC_W), .WORD_W(WORD_W), .MAX_LOC(MAX_LOC)) dut (
    .clk(clk), .rst(rst),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_loc_valid(o_loc_valid), .i_loc_ready(i_loc_ready),
    .o_loc_data(o_loc_data), .o_loc_ord(o_loc_ord),
    .o_done_valid(o_done_valid), .i_done_ready(i_done_ready),
    .o_done_count(o_done_count), .o_done_trunc(o_done_trunc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Model: the expected beat list is simply the set-bit indices in scan order, truncated at the cap
  typedef struct {int loc; int ord;} beat_t;
  beat_t expQ[$];
  int    mTotal, mBeats, mStalls, mEdges;
  bit    mActive = 1'b0;

  function automatic void buildModel(input logic [VEC_W-1:0] v);
    expQ.delete();
    mTotal = 0;
    for (int i = 0; i < VEC_W; i++) begin
      int idx;
`ifdef HWSCAN_MSB_FIRST_EN
      idx = VEC_W - 1 - i;
`else
      idx = i;
`endif
      if (v[idx]) begin
        mTotal++;
        if (expQ.size() < MAX_LOC) expQ.push_back('{loc: idx, ord: expQ.size()});
      end
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mActive = 1'b0;
        expQ.delete();
        checkOutput("rstInReady", 32'(o_in_ready), 1);
        checkOutput("rstLocValid", 32'(o_loc_valid), 0);
        checkOutput("rstLocData", 32'(o_loc_data), 0);
        checkOutput("rstLocOrd", 32'(o_loc_ord), 0);
        checkOutput("rstDoneValid", 32'(o_done_valid), 0);
        checkOutput("rstDoneCount", 32'(o_done_count), 0);
        checkOutput("rstDoneTrunc", 32'(o_done_trunc), 0);
      end else if (mActive) begin
        mEdges++;
        checkOutput("busyInReady", 32'(o_in_ready), 0);
        if (o_loc_valid) begin
          if (expQ.size() == 0) checkOutput("extraBeat", 32'(o_loc_valid), 0);
          else begin
            checkOutput("locData", 32'(o_loc_data), expQ[0].loc);
            checkOutput("locOrd", 32'(o_loc_ord), expQ[0].ord);
            if (i_loc_ready) void'(expQ.pop_front());
            else mStalls++;
          end
        end
        checkOutput("doneTiming", 32'(o_done_valid), 32'(mEdges >= NWORDS + mBeats + mStalls));
        if (o_done_valid) begin
          checkOutput("doneCount", 32'(o_done_count), mTotal);
          checkOutput("doneTrunc", 32'(o_done_trunc), 32'(mTotal > MAX_LOC));
          checkOutput("beatsLeft", expQ.size(), 0);
          if (i_done_ready) mActive = 1'b0;
        end
      end else begin
        checkOutput("idleInReady", 32'(o_in_ready), 1);
        checkOutput("idleLocValid", 32'(o_loc_valid), 0);
        checkOutput("idleDoneValid", 32'(o_done_valid), 0);
        if (i_in_valid) begin
          buildModel(i_in_data);
          mBeats  = expQ.size();
          mStalls = 0;
          mEdges  = -1;
          mActive = 1'b1;
        end
      end
    end
  end

  int   obsLoc[$];
  int   obsOrd[$];
  int   obsDoneCyc;
  int   obsCount;
  int   obsTrunc;
  logic doneSeen;

  // One transaction; cycle numbers count edges after the accept edge
  task automatic applyStimulus(input logic [VEC_W-1:0] vec, input int locStall,
                               input int doneStall, input int abortAfter);
    int cyc;
    int stallLeft;
    int doneLeft;
    obsLoc.delete();
    obsOrd.delete();
    obsDoneCyc = -1;
    obsCount   = -1;
    obsTrunc   = -1;
    doneSeen   = 1'b0;
    stallLeft  = locStall;
    doneLeft   = doneStall;
    i_in_data    = vec;
    i_in_valid   = 1'b1;
    i_loc_ready  = 1'b1;
    i_done_ready = 1'b0;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    cyc = 0;
    while (cyc < 300) begin
      if (abortAfter >= 0 && obsLoc.size() == abortAfter) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
      if (o_done_valid) begin
        if (!doneSeen) begin
          doneSeen   = 1'b1;
          obsDoneCyc = cyc;
          obsCount   = int'(o_done_count);
          obsTrunc   = int'(o_done_trunc);
        end
        if (doneLeft > 0) begin
          i_done_ready = 1'b0;
          doneLeft--;
        end else begin
          i_done_ready = 1'b1;
          @(posedge clk); #1;
          i_done_ready = 1'b0;
          break;
        end
      end else if (o_loc_valid && stallLeft > 0) begin
        i_loc_ready = 1'b0;
        stallLeft--;
      end else begin
        i_loc_ready = 1'b1;
        if (o_loc_valid) begin
          obsLoc.push_back(int'(o_loc_data));
          obsOrd.push_back(int'(o_loc_ord));
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_loc_ready = 1'b1;
    if (abortAfter < 0) checkOutput("doneSeen", 32'(doneSeen), 1);
  endtask

  logic [VEC_W-1:0] v;
  int t2Loc[4];
  int t6Loc[2];

  initial begin
`ifdef HWSCAN_MSB_FIRST_EN
    t2Loc = '{1023, 32, 31, 0};
    t6Loc = '{1000, 3};
`else
    t2Loc = '{0, 31, 32, 1023};
    t6Loc = '{3, 1000};
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus('0, 0, 0, -1);
    checkOutput("t1Beats", obsLoc.size(), 0);
    checkOutput("t1DoneCyc", obsDoneCyc, 32);
    checkOutput("t1Count", obsCount, 0);
    checkOutput("t1Trunc", obsTrunc, 0);

    v = '0; v[0] = 1'b1; v[31] = 1'b1; v[32] = 1'b1; v[1023] = 1'b1;
    applyStimulus(v, 0, 0, -1);
    checkOutput("t2Beats", obsLoc.size(), 4);
    for (int i = 0; i < obsLoc.size() && i < 4; i++) begin
      checkOutput($sformatf("t2Loc%0d", i), obsLoc[i], t2Loc[i]);
      checkOutput($sformatf("t2Ord%0d", i), obsOrd[i], i);
    end
    checkOutput("t2DoneCyc", obsDoneCyc, 36);
    checkOutput("t2Count", obsCount, 4);
    checkOutput("t2Trunc", obsTrunc, 0);

    v = '1;
    applyStimulus(v, 0, 0, -1);
    checkOutput("t3Beats", obsLoc.size(), 32);
    for (int i = 0; i < obsLoc.size() && i < 32; i++) begin
`ifdef HWSCAN_MSB_FIRST_EN
      checkOutput($sformatf("t3Loc%0d", i), obsLoc[i], 1023 - i);
`else
      checkOutput($sformatf("t3Loc%0d", i), obsLoc[i], i);
`endif
      checkOutput($sformatf("t3Ord%0d", i), obsOrd[i], i);
    end
    checkOutput("t3DoneCyc", obsDoneCyc, 64);
    checkOutput("t3Count", obsCount, 1024);
    checkOutput("t3Trunc", obsTrunc, 1);

    v = '0; v[5] = 1'b1; v[700] = 1'b1;
    applyStimulus(v, 5, 3, -1);
    checkOutput("t4Beats", obsLoc.size(), 2);
`ifdef HWSCAN_MSB_FIRST_EN
    checkOutput("t4Loc0", obsLoc[0], 700);
`else
    checkOutput("t4Loc0", obsLoc[0], 5);
`endif
    checkOutput("t4DoneCyc", obsDoneCyc, 39);
    checkOutput("t4Count", obsCount, 2);

    v = '0;
    for (int i = 0; i < 10; i++) v[i] = 1'b1;
    applyStimulus(v, 0, 0, 3);
    checkOutput("t5AbortBeats", obsLoc.size(), 3);
    checkOutput("t5InReady", 32'(o_in_ready), 1);
    checkOutput("t5LocValid", 32'(o_loc_valid), 0);
    checkOutput("t5DoneValid", 32'(o_done_valid), 0);
    checkOutput("t5LocData", 32'(o_loc_data), 0);
    v = '0; v[2] = 1'b1;
    applyStimulus(v, 0, 0, -1);
    checkOutput("t5Beats", obsLoc.size(), 1);
    checkOutput("t5Loc", obsLoc[0], 2);
    checkOutput("t5Ord", obsOrd[0], 0);
    checkOutput("t5Count", obsCount, 1);
    checkOutput("t5DoneCyc", obsDoneCyc, 33);

    v = '0; v[3] = 1'b1; v[1000] = 1'b1;
    applyStimulus(v, 0, 0, -1);
    checkOutput("t6Beats", obsLoc.size(), 2);
    for (int i = 0; i < obsLoc.size() && i < 2; i++) begin
      checkOutput($sformatf("t6Loc%0d", i), obsLoc[i], t6Loc[i]);
      checkOutput($sformatf("t6Ord%0d", i), obsOrd[i], i);
    end
    checkOutput("t6Count", obsCount, 2);
    checkOutput("t6DoneCyc", obsDoneCyc, 34);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
